// File: rtl/bird_datapath_if.sv
// Bird datapath bus: FSM state code in, position, VGA pixel stream
// and status flags out. master = FSM side, slave = datapath side.
interface bird_datapath_if;
    logic [3:0] state;
    logic [7:0] bird_x;
    logic [6:0] bird_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       done_drawing;
    logic       flying;

    modport master (
        output state,
        input  bird_x, bird_y, vga_x, vga_y,
        input  colour, plot, done_drawing, flying
    );

    modport slave (
        input  state,
        output bird_x, bird_y, vga_x, vga_y,
        output colour, plot, done_drawing, flying
    );
endinterface

// File: rtl/bird_datapath.sv
// Bird datapath: position, fall/escape animation and sprite scan to VGA.
// Ports: clk, reset (sync, active-high), bus (bird_datapath_if.slave).
module bird_datapath #(
    parameter int unsigned BIRD_W      = 8,
    parameter int unsigned BIRD_H      = 8,
    parameter int unsigned STEP        = 2,
    parameter int unsigned FALL_STEP   = 4,
    parameter int unsigned ESC_STEP    = 4,
    parameter int unsigned START_X     = 76,
    parameter int unsigned START_Y     = 90,
    parameter int unsigned Y_FLOOR     = 100,
    parameter logic [2:0]  BG_COLOUR   = 3'b011,
    parameter logic [2:0]  BIRD_COLOUR = 3'b100,
    parameter logic [2:0]  HIT_COLOUR  = 3'b110
) (
    input logic            clk,
    input logic            reset,
    bird_datapath_if.slave bus
);
    localparam logic [3:0] S_PREHOLD = 4'b0100;
    localparam logic [3:0] S_CLEAR   = 4'b0001;
    localparam logic [3:0] S_UP_R    = 4'b0011;
    localparam logic [3:0] S_UP_L    = 4'b0010;
    localparam logic [3:0] S_DN_R    = 4'b0110;
    localparam logic [3:0] S_DN_L    = 4'b0111;
    localparam logic [3:0] S_DRAW    = 4'b0101;
    localparam logic [3:0] S_SHOT    = 4'b1000;
    localparam logic [3:0] S_ESCAPE  = 4'b1001;
    localparam logic [3:0] S_RESET   = 4'b1010;

    localparam int unsigned PIX = BIRD_W * BIRD_H;
    localparam int unsigned CW  = $clog2(PIX);
    localparam logic [CW-1:0] LAST = CW'(PIX - 1);

    localparam logic signed [8:0] STEP_S = 9'(STEP);
    localparam logic signed [8:0] FALL_S = 9'(FALL_STEP);
    localparam logic signed [8:0] ESC_S  = 9'(ESC_STEP);
    localparam logic signed [8:0] X_MAX  = 9'(160 - BIRD_W);
    localparam logic signed [8:0] Y_MAX  = 9'(Y_FLOOR);

    typedef enum logic [1:0] {
        M_NORMAL, M_FALL, M_ESC, M_DONE
    } mode_e;

    logic [3:0]    state_q;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    mode_e         mode_q, mode_d;

    logic              entry, scan_st;
    logic signed [8:0] mx, my;
    logic [6:0]        fall_y, esc_y;

    function automatic logic [7:0] clamp_x(input logic signed [8:0] v);
        if (v < 0)          return 8'd0;
        else if (v > X_MAX) return X_MAX[7:0];
        else                return v[7:0];
    endfunction

    function automatic logic [6:0] clamp_y(input logic signed [8:0] v);
        if (v < 0)          return 7'd0;
        else if (v > Y_MAX) return Y_MAX[6:0];
        else                return v[6:0];
    endfunction

    assign entry   = (bus.state != state_q);
    assign scan_st = (bus.state == S_CLEAR) || (bus.state == S_DRAW);
    assign fall_y  = clamp_y($signed({2'b00, y_q}) + FALL_S);
    assign esc_y   = clamp_y($signed({2'b00, y_q}) - ESC_S);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_PREHOLD;
            x_q     <= 8'(START_X);
            y_q     <= 7'(START_Y);
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mode_q  <= M_NORMAL;
        end else begin
            state_q <= bus.state;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
        end
    end

    // Mode next-state
    always_comb begin
        mode_d = mode_q;
        if (bus.state == S_RESET) begin
            mode_d = M_NORMAL;
        end else if (entry) begin
            case (bus.state)
                S_SHOT:   if (mode_q == M_NORMAL) mode_d = M_FALL;
                S_ESCAPE: if (mode_q == M_NORMAL) mode_d = M_ESC;
                S_DRAW: begin
                    if (mode_q == M_FALL && fall_y == Y_MAX[6:0])
                        mode_d = M_DONE;
                    if (mode_q == M_ESC && esc_y == 7'd0)
                        mode_d = M_DONE;
                end
                default: ;
            endcase
        end
    end

    // Position and scan counter
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        mx     = $signed({1'b0, x_q});
        my     = $signed({2'b00, y_q});
        case (bus.state)
            S_UP_R: begin mx = mx + STEP_S; my = my - STEP_S; end
            S_UP_L: begin mx = mx - STEP_S; my = my - STEP_S; end
            S_DN_R: begin mx = mx + STEP_S; my = my + STEP_S; end
            S_DN_L: begin mx = mx - STEP_S; my = my + STEP_S; end
            default: ;
        endcase

        if (bus.state == S_RESET) begin
            x_d = 8'(START_X);
            y_d = 7'(START_Y);
        end else if (entry) begin
            // mx/my differ from the current position only in move states
            x_d = clamp_x(mx);
            y_d = clamp_y(my);
            if (bus.state == S_DRAW && mode_q == M_FALL) y_d = fall_y;
            if (bus.state == S_DRAW && mode_q == M_ESC)  y_d = esc_y;
        end

        if (!scan_st || entry) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (!done_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) done_d = 1'b1;
        end
    end

    // Outputs
    always_comb begin
        bus.bird_x       = x_q;
        bus.bird_y       = y_q;
        bus.plot         = scan_st && !entry && !done_q;
        bus.vga_x        = x_q + 8'(cnt_q % BIRD_W);
        bus.vga_y        = y_q + 7'(cnt_q / BIRD_W);
        bus.done_drawing = done_q && !entry;
        bus.flying       = (mode_q == M_FALL) || (mode_q == M_ESC) ||
                           (((bus.state == S_SHOT) ||
                             (bus.state == S_ESCAPE)) &&
                            (mode_q == M_NORMAL));
        bus.colour       = 3'b000;
        if (bus.plot) begin
            if (bus.state == S_CLEAR)    bus.colour = BG_COLOUR;
            else if (mode_q == M_FALL)   bus.colour = HIT_COLOUR;
            else                         bus.colour = BIRD_COLOUR;
        end
    end
endmodule

// File: tb/tb_bird_datapath.sv
// Randomised + directed bench for bird_datapath against a per-cycle
// integer model of position, mode and the row-major sprite scan.
module tb_bird_datapath;
    localparam logic [3:0] HOLD = 4'b0000, CLEAR = 4'b0001;
    localparam logic [3:0] UR = 4'b0011, UL = 4'b0010;
    localparam logic [3:0] DR = 4'b0110, DL = 4'b0111;
    localparam logic [3:0] DRAW = 4'b0101, SHOT = 4'b1000;
    localparam logic [3:0] ESC = 4'b1001, RST = 4'b1010;
    localparam logic [3:0] PREHOLD = 4'b0100;

    localparam int NORMAL = 0, FALL = 1, ESCP = 2, DONE = 3;

    logic clk = 1'b0;
    logic reset;
    bird_datapath_if bus();

    bird_datapath dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0, n_fail = 0;

    int m_x, m_y, m_mode, m_idx;
    bit m_done;
    logic [3:0] m_ps;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s got %0d expected %0d at %0t",
                         tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic bit is_scan(input logic [3:0] s);
        return (s == CLEAR) || (s == DRAW);
    endfunction

    task automatic model_reset();
        m_x = 76; m_y = 90; m_mode = NORMAL;
        m_idx = 0; m_done = 0; m_ps = PREHOLD;
    endtask

    task automatic model_check(input logic [3:0] s);
        bit entry, e_plot, e_fly;
        int e_col;
        entry  = (s != m_ps);
        e_plot = is_scan(s) && !entry && !m_done;
        e_fly  = (m_mode == FALL) || (m_mode == ESCP) ||
                 (((s == SHOT) || (s == ESC)) && m_mode == NORMAL);
        chk("bird_x", int'(bus.bird_x), m_x);
        chk("bird_y", int'(bus.bird_y), m_y);
        chk("plot", int'(bus.plot), int'(e_plot));
        chk("done_drawing", int'(bus.done_drawing),
            int'(m_done && !entry));
        chk("flying", int'(bus.flying), int'(e_fly));
        if (e_plot) begin
            e_col = (s == CLEAR) ? 3 : (m_mode == FALL ? 6 : 4);
            chk("vga_x", int'(bus.vga_x), m_x + m_idx % 8);
            chk("vga_y", int'(bus.vga_y), m_y + m_idx / 8);
            chk("colour", int'(bus.colour), e_col);
        end
    endtask

    task automatic model_step(input logic [3:0] s, input logic r);
        bit entry;
        entry = (s != m_ps);
        if (r) begin
            model_reset();
            return;
        end
        if (s == RST) begin
            m_mode = NORMAL; m_x = 76; m_y = 90;
        end else if (entry) begin
            case (s)
                UR: begin m_x += 2; m_y -= 2; end
                UL: begin m_x -= 2; m_y -= 2; end
                DR: begin m_x += 2; m_y += 2; end
                DL: begin m_x -= 2; m_y += 2; end
                SHOT: if (m_mode == NORMAL) m_mode = FALL;
                ESC:  if (m_mode == NORMAL) m_mode = ESCP;
                DRAW: begin
                    if (m_mode == FALL) begin
                        m_y = clampi(m_y + 4, 0, 100);
                        if (m_y == 100) m_mode = DONE;
                    end else if (m_mode == ESCP) begin
                        m_y = clampi(m_y - 4, 0, 100);
                        if (m_y == 0) m_mode = DONE;
                    end
                end
                default: ;
            endcase
            m_x = clampi(m_x, 0, 152);
            m_y = clampi(m_y, 0, 100);
        end
        if (is_scan(s)) begin
            if (entry) begin
                m_idx = 0; m_done = 0;
            end else if (!m_done) begin
                if (m_idx == 63) m_done = 1;
                else m_idx++;
            end
        end else begin
            m_idx = 0; m_done = 0;
        end
        m_ps = s;
    endtask

    // Drive at posedge+1, check at the falling edge, advance model.
    task automatic cycle(input logic [3:0] s, input logic r);
        bus.state = s;
        reset = r;
        #4;
        model_check(s);
        @(posedge clk);
        model_step(s, r);
        #1;
    endtask

    task automatic hold(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) cycle(s, 1'b0);
    endtask

    task automatic do_reset();
        cycle(HOLD, 1'b1);
        cycle(HOLD, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        bus.state = HOLD;
        @(posedge clk);
        #1;
        model_reset();
        do_reset();
        chk("rst_x", int'(bus.bird_x), 76);
        chk("rst_y", int'(bus.bird_y), 90);

        // Clear scan, then move and draw
        hold(CLEAR, 70);
        chk("clear_done", int'(bus.done_drawing), 1);
        cycle(UR, 1'b0);
        hold(DRAW, 66);
        chk("ur_x", int'(bus.bird_x), 78);
        chk("ur_y", int'(bus.bird_y), 88);

        // Clamp at right edge and floor
        do_reset();
        for (int i = 0; i < 45; i++) begin
            cycle(DR, 1'b0);
            cycle(HOLD, 1'b0);
        end
        chk("clamp_x", int'(bus.bird_x), 152);
        chk("clamp_y", int'(bus.bird_y), 100);

        // Shot and fall
        do_reset();
        hold(DRAW, 66);
        cycle(SHOT, 1'b0);
        hold(SHOT, 2);
        for (int i = 0; i < 4; i++) begin
            hold(CLEAR, 66);
            hold(DRAW, 66);
        end
        chk("fall_y", int'(bus.bird_y), 100);
        chk("fall_fly", int'(bus.flying), 0);
        hold(RST, 2);
        chk("rst_state_x", int'(bus.bird_x), 76);
        chk("rst_state_y", int'(bus.bird_y), 90);

        // Escape from y = 6
        do_reset();
        for (int i = 0; i < 42; i++) begin
            cycle(UL, 1'b0);
            cycle(HOLD, 1'b0);
        end
        chk("esc_start_y", int'(bus.bird_y), 6);
        hold(ESC, 2);
        for (int i = 0; i < 3; i++) begin
            hold(CLEAR, 66);
            hold(DRAW, 66);
        end
        chk("esc_y", int'(bus.bird_y), 0);
        chk("esc_fly", int'(bus.flying), 0);
        hold(RST, 2);
        chk("esc_rst_fly", int'(bus.flying), 0);

        // Reset mid-scan at pixel 30
        do_reset();
        cycle(UR, 1'b0);
        hold(DRAW, 31);
        cycle(DRAW, 1'b1);
        chk("mid_plot", int'(bus.plot), 0);
        chk("mid_x", int'(bus.bird_x), 76);
        chk("mid_y", int'(bus.bird_y), 90);
        chk("mid_done", int'(bus.done_drawing), 0);
        hold(DRAW, 70);

        // Random state sequences
        for (int seg = 0; seg < 300; seg++) begin
            logic [3:0] s;
            int len;
            s = 4'($urandom_range(0, 15));
            len = is_scan(s) ? int'($urandom_range(1, 70))
                             : int'($urandom_range(1, 3));
            if ($urandom_range(0, 39) == 0) cycle(s, 1'b1);
            hold(s, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bird_datapath.md
Name: bird_datapath

Overview:
- Datapath partner of the bird control FSM. It consumes the FSM's 4-bit state code and produces the done_drawing and flying status signals that the FSM consumes.
- Owns the bird position and the falling/escaping animation.
- Scans the bird sprite box one pixel per cycle into the 160x120 VGA adapter, both to erase and to draw.

Parameters:
- BIRD_W, 8: sprite width in pixels.
- BIRD_H, 8: sprite height in pixels.
- STEP, 2: pixels moved per axis per move state.
- FALL_STEP, 4: pixels per frame while falling (y increases).
- ESC_STEP, 4: pixels per frame while escaping (y decreases).
- START_X, 76: bird x after reset and after S_RESET.
- START_Y, 90: bird y after reset and after S_RESET.
- Y_FLOOR, 100: max y; a falling bird stops here.
- BG_COLOUR, 3'b011: erase colour.
- BIRD_COLOUR, 3'b100: normal draw colour.
- HIT_COLOUR, 3'b110: draw colour while falling.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- state  in  4  FSM state code
- bird_x  out  8  sprite top-left x
- bird_y  out  7  sprite top-left y
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  write enable to VGA adapter
- done_drawing  out  1  erase/draw scan complete
- flying  out  1  bird falling or escaping, animation not yet finished

Behaviour:
- Clocking and reset: one clock. reset is synchronous and active-high.
- Reset values:
  - bird_x = START_X, bird_y = START_Y.
  - mode = NORMAL, pixel counter = 0, done_flag = 0, state_q = 4'b0100.
  - plot = 0, colour = 0, done_drawing = 0, flying = 0.
- State codes:
  - PREHOLD 0100, HOLD 0000, CLEAR 0001.
  - UP_RIGHT 0011, UP_LEFT 0010, DOWN_RIGHT 0110, DOWN_LEFT 0111.
  - DRAW 0101, SHOT 1000, ESCAPE 1001, RESET 1010.
  - Undefined codes behave like HOLD.
- state_q is the registered copy of state.
- Entry rule: a state is "entered" when state != state_q.
- Scan in CLEAR/DRAW:
  - On entry: counter = 0, done_flag = 0.
  - Each following cycle with done_flag = 0, emit one pixel and increment the counter:
    - plot = 1.
    - vga_x = bird_x + col, vga_y = bird_y + row, with col = counter mod BIRD_W and row = counter / BIRD_W.
  - Scan order is row-major, one pixel per cycle.
  - After pixel BIRD_W*BIRD_H-1: done_flag = 1, plot = 0.
  - Latency: W*H pixel cycles; done visible on cycle W*H+1 after entry. Default is 64 pixels, done on cycle 65.
- Pixel colour:
  - CLEAR: BG_COLOUR.
  - DRAW: HIT_COLOUR if mode = FALL, else BIRD_COLOUR.
- done_drawing = done_flag & (state == state_q), combinational.
  - It is never high in the first cycle of any state, which covers the direct CLEAR->DRAW path.
  - done_flag also clears in every state other than CLEAR/DRAW.
- Move states (one cycle each, applied once on entry):
  - UP_RIGHT: x += STEP, y -= STEP.
  - UP_LEFT: x -= STEP, y -= STEP.
  - DOWN_RIGHT: x += STEP, y += STEP.
  - DOWN_LEFT: x -= STEP, y += STEP.
  - Clamp x to [0, 160-BIRD_W] and y to [0, Y_FLOOR].
  - Compute in 9-bit signed arithmetic; no wrap-around.
- Mode register (NORMAL, FALL, ESCAPE, DONE):
  - SHOT entered with mode = NORMAL -> FALL.
  - ESCAPE entered with mode = NORMAL -> ESCAPE.
  - SHOT/ESCAPE entered with mode != NORMAL: no change.
  - DRAW entered with mode = FALL: y = min(y+FALL_STEP, Y_FLOOR). If the result equals Y_FLOOR, mode -> DONE.
  - DRAW entered with mode = ESCAPE: y = max(y-ESC_STEP, 0). If the result equals 0, mode -> DONE.
  - The position update happens before the scan reads the position (same entry cycle).
  - RESET state: mode = NORMAL, position = START_X/START_Y, done_flag = 0.
- flying = (mode == FALL | mode == ESCAPE) | ((state == SHOT | state == ESCAPE) & mode == NORMAL), combinational.
  - This gives the FSM a same-cycle flying = 1 on the first SHOT/ESCAPE visit.
  - flying = 0 once mode = DONE, so the FSM proceeds to RESET.
- Reset mid-scan: aborts the scan immediately; all registers return to reset values next cycle.
- state changing mid-scan: the scan restarts per the entry rule; a partial scan is never resumed.

Test Plan:
- Reset, then state = CLEAR held -> 64 plot pulses, BG_COLOUR, vga_x 76..83, vga_y 90..97; done_drawing high on cycle 65 and stays high.
- Sequence CLEAR (done) -> UP_RIGHT -> DRAW -> bird_x = 78, bird_y = 88; done_drawing = 0 during UP_RIGHT and the first DRAW cycle; 64 BIRD_COLOUR pixels follow.
- bird_x = 152 with DOWN_RIGHT repeated -> x clamps at 152; bird_y clamps at 100, never wraps.
- DRAW -> SHOT -> flying = 1 in the first SHOT cycle. Then repeat CLEAR -> DRAW loops from bird_y = 90 -> y 94, 98, 100; HIT_COLOUR pixels; flying = 0 after y = 100; RESET restores (76, 90).
- ESCAPE from bird_y = 6 -> y 2, then 0; flying drops; RESET sets mode NORMAL and flying = 0.
- Assert reset at pixel 30 of a DRAW scan -> plot = 0 next cycle; position (76, 90); done_drawing = 0.
